// File: rtl/burst_address_arbiter.sv
// burst_address_arbiter
//
// Shares the frame-memory address sequence between two requesters. The
// winner's base and length are latched, one address is issued per clock
// with wrap from MAX_ADDRESS to 0, and a one-cycle done pulse marks the end
// of the burst.
//
// Build option: define BURST_ARB_RR_EN for round-robin arbitration with a
// last-granted pointer. Leave it undefined for fixed priority, where
// requester 0 always wins contention.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   req[1:0]     request per requester, held until its done bit
//   base0/base1  burst start address per requester
//   len0/len1    burst length per requester (0 allowed)
//   grant[1:0]   one-hot owner of the active burst, 0 otherwise
//   address      current memory address
//   addr_valid   address is a live burst address this cycle
//   done[1:0]    one-cycle pulse when the owner's burst ends
//   busy         high whenever the FSM is not idle
module burst_address_arbiter #(
    parameter int MAX_ADDRESS = 20,
    parameter int BITWIDTH    = 5,
    parameter int LEN_WIDTH   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req,
    input  logic [BITWIDTH-1:0]  base0,
    input  logic [BITWIDTH-1:0]  base1,
    input  logic [LEN_WIDTH-1:0] len0,
    input  logic [LEN_WIDTH-1:0] len1,
    output logic [1:0]           grant,
    output logic [BITWIDTH-1:0]  address,
    output logic                 addr_valid,
    output logic [1:0]           done,
    output logic                 busy
);

    localparam logic [BITWIDTH-1:0] MAX_A = BITWIDTH'(MAX_ADDRESS);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t               state;
    logic                 owner;      // index of the requester owning the burst
    logic [LEN_WIDTH-1:0] remaining;  // addresses still to issue after the current one

`ifdef BURST_ARB_RR_EN
    logic                 last;       // last-granted requester
`endif

    logic                 pick;
    logic [BITWIDTH-1:0]  sel_base;
    logic [BITWIDTH-1:0]  start_addr;
    logic [LEN_WIDTH-1:0] sel_len;
    logic [BITWIDTH-1:0]  next_addr;

    // Winner selection; only consumed when at least one request is high.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
`ifdef BURST_ARB_RR_EN
            pick = ~last;
`else
            pick = 1'b0;
`endif
        end else begin
            pick = ~req[0];
        end
    end

    always_comb begin
        sel_base   = pick ? base1 : base0;
        sel_len    = pick ? len1  : len0;
        // An out-of-range base starts the burst at address 0.
        start_addr = (sel_base > MAX_A) ? '0 : sel_base;
        next_addr  = (address == MAX_A) ? '0 : address + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            address    <= '0;
            addr_valid <= 1'b0;
            done       <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            remaining  <= '0;
`ifdef BURST_ARB_RR_EN
            last       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        owner <= pick;
                        busy  <= 1'b1;
`ifdef BURST_ARB_RR_EN
                        last  <= pick;
`endif
                        if (sel_len == '0) begin
                            // Empty burst: straight to completion, address untouched.
                            state <= DONE;
                            done  <= {pick, ~pick};
                        end else begin
                            state      <= BURST;
                            grant      <= {pick, ~pick};
                            addr_valid <= 1'b1;
                            address    <= start_addr;
                            remaining  <= sel_len - 1'b1;
                        end
                    end
                end

                BURST: begin
                    if (remaining == '0) begin
                        state      <= DONE;
                        grant      <= '0;
                        addr_valid <= 1'b0;
                        done       <= {owner, ~owner};
                    end else begin
                        address   <= next_addr;
                        remaining <= remaining - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    busy  <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    grant      <= '0;
                    addr_valid <= 1'b0;
                    done       <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
